// File: rtl/mdu_pkg.sv
// Shared RV32M multiply/divide op codes and op-class helpers.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  function automatic logic op_is_div(logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_sgn_a(logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU)
        || (op == MDU_DIV)  || (op == MDU_REM);
  endfunction

  function automatic logic op_sgn_b(logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV)
        || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the execute stage and the mdu.
interface mdu_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] r;
  logic            bsy;
  logic            done;

  modport master (
    output start, op, a, b,
    input  r, bsy, done
  );

  modport slave (
    input  start, op, a, b,
    output r, bsy, done
  );
endinterface

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide: radix-2 shift/add
// multiply, restoring divide, XLEN steps per op.
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  state_t            r_state;
  state_t            w_state_nx;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic              r_qneg;
  logic              r_rneg;
  logic              r_spec;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_res;
  logic              r_done;

  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_amag;
  logic [XLEN-1:0]   w_bmag;
  logic              w_dz;
  logic              w_ovf;
  logic              w_spec;
  logic [XLEN-1:0]   w_pre;
  logic              w_div;
  logic [XLEN+1:0]   w_x;
  logic [XLEN+1:0]   w_y;
  logic [XLEN+1:0]   w_sum;
  logic [XLEN:0]     w_acc;
  logic              w_ok;
  logic [XLEN-1:0]   w_hi_nx;
  logic [XLEN-1:0]   w_lo_nx;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_res;

  // Unsigned XLEN-bit magnitude of the most-negative value is exact.
  assign w_sa   = bus.a[XLEN-1] & op_sgn_a(bus.op);
  assign w_sb   = bus.b[XLEN-1] & op_sgn_b(bus.op);
  assign w_amag = w_sa ? (~bus.a + 1'b1) : bus.a;
  assign w_bmag = w_sb ? (~bus.b + 1'b1) : bus.b;

  assign w_dz   = op_is_div(bus.op) && (bus.b == '0);
  assign w_ovf  = ((bus.op == MDU_DIV) || (bus.op == MDU_REM))
               && (bus.a == {1'b1, {(XLEN-1){1'b0}}})
               && (bus.b == '1);
  assign w_spec = w_dz || w_ovf;

  always_comb begin
    w_pre = '0;
    unique case (1'b1)
      w_dz:    w_pre = bus.op[1] ? bus.a : '1;
      w_ovf:   w_pre = bus.op[1] ? '0 : bus.a;
      default: w_pre = '0;
    endcase
  end

  // Shared adder: add multiplicand, or trial-subtract divisor.
  assign w_div = op_is_div(r_op);
  assign w_x   = w_div ? {1'b0, r_hi, r_lo[XLEN-1]}
                       : {2'b00, r_hi};
  assign w_y   = {2'b00, r_b};
  assign w_sum = w_x + (w_div ? ~w_y : w_y)
               + (XLEN+2)'(w_div);

  assign w_acc = r_lo[0] ? w_sum[XLEN:0] : {1'b0, r_hi};
  assign w_ok  = ~w_sum[XLEN+1];

  always_comb begin
    w_hi_nx = w_acc[XLEN:1];
    w_lo_nx = {w_acc[0], r_lo[XLEN-1:1]};
    if (w_div) begin
      w_hi_nx = w_ok ? w_sum[XLEN-1:0] : w_x[XLEN-1:0];
      w_lo_nx = {r_lo[XLEN-2:0], w_ok};
    end
  end

  assign w_prod = r_qneg ? (~{r_hi, r_lo} + 1'b1) : {r_hi, r_lo};
  assign w_quot = r_qneg ? (~r_lo + 1'b1) : r_lo;
  assign w_rem  = r_rneg ? (~r_hi + 1'b1) : r_hi;

  always_comb begin
    w_res = w_rem;
    unique case (r_op)
      MDU_MUL:    w_res = w_prod[XLEN-1:0];
      MDU_MULH,
      MDU_MULHSU,
      MDU_MULHU:  w_res = w_prod[2*XLEN-1:XLEN];
      MDU_DIV,
      MDU_DIVU:   w_res = w_quot;
      default:    w_res = w_rem;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE: if (bus.start) w_state_nx = w_spec ? FIX : CALC;
      CALC: if (r_cnt == LAST) w_state_nx = FIX;
      FIX:  w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= MDU_MUL;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_spec  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_done  <= 1'b0;
      unique case (r_state)
        IDLE: if (bus.start) begin
          r_op   <= bus.op;
          r_qneg <= w_sa ^ w_sb;
          r_rneg <= w_sa;
          r_spec <= w_spec;
          r_cnt  <= '0;
          r_hi   <= '0;
          r_b    <= w_bmag;
          r_lo   <= w_spec ? w_pre : w_amag;
        end
        CALC: begin
          r_cnt <= r_cnt + 1'b1;
          r_hi  <= w_hi_nx;
          r_lo  <= w_lo_nx;
        end
        FIX: begin
          r_res  <= r_spec ? r_lo : w_res;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.r    = r_res;
  assign bus.done = r_done;
  assign bus.bsy  = bus.start | (r_state != IDLE);

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed table, corner
// sequences and random ops against an arithmetic model.
module tb_mdu;
  import mdu_pkg::*;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  mdu_if #(.XLEN(XLEN)) bus ();

  mdu #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(
    input logic [2:0] op,
    input logic [31:0] a,
    input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    logic [63:0] p;
    logic [31:0] mn;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    mn = 32'h8000_0000;
    p  = '0;
    case (op)
      MDU_MUL:    begin p = ua * ub; return p[31:0];  end
      MDU_MULH:   begin p = sa * sb; return p[63:32]; end
      MDU_MULHSU: begin p = sa * ub; return p[63:32]; end
      MDU_MULHU:  begin p = ua * ub; return p[63:32]; end
      MDU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == mn && b == 32'hFFFF_FFFF) return a;
        p = sa / sb;
        return p[31:0];
      end
      MDU_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      MDU_REM: begin
        if (b == 0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'(signed'($urandom_range(0, 40)) - 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op; report result, done latency from the start
  // cycle, bsy-high cycle count and number of done pulses.
  task automatic run(input logic [2:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input bit noise,
                     output logic [31:0] res,
                     output int lat,
                     output int bcnt,
                     output int dcnt);
    res  = '0;
    lat  = 0;
    dcnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    #1;
    bcnt = bus.bsy ? 1 : 0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.bsy) bcnt++;
      if (bus.done) begin
        dcnt++;
        if (lat == 0) begin
          lat = k;
          res = bus.r;
        end
      end
      if (noise && (k == 3 || k == 10)) begin
        bus.start = 1'b1;
        bus.op = ~op;
        bus.a  = $urandom;
        bus.b  = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      if (lat != 0 && k >= lat + 3) break;
    end
    bus.start = 1'b0;
  endtask

  vec_t        tv[13];
  logic [31:0] res;
  logic [31:0] exp;
  int          lat;
  int          bcnt;
  int          dcnt;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;

  initial begin
    tv[0]  = '{MDU_MUL,    32'd7,        32'hFFFF_FFFD,
               32'hFFFF_FFEB, LAT};
    tv[1]  = '{MDU_MULH,   32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, LAT};
    tv[2]  = '{MDU_MULHSU, 32'h8000_0000, 32'h8000_0000,
               32'hC000_0000, LAT};
    tv[3]  = '{MDU_MULHU,  32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, LAT};
    tv[4]  = '{MDU_DIV,    32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFD, LAT};
    tv[5]  = '{MDU_REM,    32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, LAT};
    tv[6]  = '{MDU_DIVU,   32'h1234,      32'd0,
               32'hFFFF_FFFF, 2};
    tv[7]  = '{MDU_REM,    32'd5,         32'd0,
               32'd5, 2};
    tv[8]  = '{MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 2};
    tv[9]  = '{MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 2};
    tv[10] = '{MDU_REMU,   32'd100,       32'd7,
               32'd2, LAT};
    tv[11] = '{MDU_DIVU,   32'hFFFF_FFFF, 32'd1,
               32'hFFFF_FFFF, LAT};
    tv[12] = '{MDU_DIV,    32'd7,         32'd0,
               32'hFFFF_FFFF, 2};

    bus.start = 1'b0;
    bus.op = '0;
    bus.a  = '0;
    bus.b  = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_r", 64'(bus.r), 64'h0);
    chk("rst_done", 64'(bus.done), 64'h0);
    chk("rst_bsy0", 64'(bus.bsy), 64'h0);
    bus.start = 1'b1;
    #1;
    chk("rst_bsy1", 64'(bus.bsy), 64'h1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 13; i++) begin
      run(tv[i].op, tv[i].a, tv[i].b, 1'b0,
          res, lat, bcnt, dcnt);
      chk($sformatf("tv%0d_r", i), 64'(res), 64'(tv[i].exp));
      chk($sformatf("tv%0d_lat", i), 64'(lat), 64'(tv[i].lat));
      chk($sformatf("tv%0d_bsy", i), 64'(bcnt), 64'(tv[i].lat));
      chk($sformatf("tv%0d_done", i), 64'(dcnt), 64'h1);
    end

    // start pulses during CALC must be ignored
    run(MDU_MUL, 32'd12345, 32'd678, 1'b1,
        res, lat, bcnt, dcnt);
    chk("noise_r", 64'(res), 64'(32'd8369910));
    chk("noise_lat", 64'(lat), 64'(LAT));
    chk("noise_done", 64'(dcnt), 64'h1);
    chk("noise_hold", 64'(bus.r), 64'(32'd8369910));

    // reset mid-CALC
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = MDU_DIV;
    bus.a  = 32'd1000;
    bus.b  = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_r", 64'(bus.r), 64'h0);
    chk("mid_rst_done", 64'(bus.done), 64'h0);
    chk("mid_rst_bsy", 64'(bus.bsy), 64'h0);
    run(MDU_DIVU, 32'd100, 32'd7, 1'b0,
        res, lat, bcnt, dcnt);
    chk("post_rst_r", 64'(res), 64'd14);
    chk("post_rst_lat", 64'(lat), 64'(LAT));

    // random ops against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = pick();
      b   = pick();
      exp = ref_mdu(op, a, b);
      run(op, a, b, 1'b0, res, lat, bcnt, dcnt);
      if (res !== exp || dcnt != 1)
        $display("  op=%0d a=%h b=%h lat=%0d", op, a, b, lat);
      chk($sformatf("rnd%0d_r", i), 64'(res), 64'(exp));
      chk($sformatf("rnd%0d_done", i), 64'(dcnt), 64'h1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
